// File: rtl/scie_pkg.sv
// Shared constants and FSM state type for the SCIE FIR sequencer.
package scie_pkg;

    // Default number of complex FIR taps.
    localparam int unsigned NTAPS = 5;

    // Opcodes issued to the downstream SCIE unit.
    localparam logic [7:0] OPC_LOAD = 8'd11;
    localparam logic [7:0] OPC_PUSH = 8'd43;
    localparam logic [7:0] OPC_READ = 8'd91;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PUSH,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/scie_fir_sequencer.sv
// Sequences coefficient loads and sample push/read commands to a pipelined
// SCIE FIR unit, and holds each filter result until it is consumed.
module scie_fir_sequencer
    import scie_pkg::*;
#(
    parameter int unsigned NTAPS = scie_pkg::NTAPS,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            coef_valid_i,
    output logic            coef_ready_o,
    input  logic [2:0]      coef_idx_i,
    input  logic [XLEN-1:0] coef_real_i,
    input  logic [XLEN-1:0] coef_imag_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_real_i,
    input  logic [XLEN-1:0] in_imag_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_real_o,
    output logic [XLEN-1:0] out_imag_o,
    output logic            scie_valid_o,
    output logic [XLEN-1:0] scie_insn_o,
    output logic [XLEN-1:0] scie_rs1_real_o,
    output logic [XLEN-1:0] scie_rs1_imag_o,
    output logic [XLEN-1:0] scie_rs2_o,
    input  logic [XLEN-1:0] scie_rd_real_i,
    input  logic [XLEN-1:0] scie_rd_imag_i,
    output logic            busy_o,
    output logic            coef_err_o
);

    localparam logic [3:0] NTAPS_L = 4'(NTAPS);

    state_e          state_q;
    logic            scie_valid_q;
    logic [XLEN-1:0] scie_insn_q;
    logic [XLEN-1:0] scie_rs1_real_q;
    logic [XLEN-1:0] scie_rs1_imag_q;
    logic [XLEN-1:0] scie_rs2_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_real_q;
    logic [XLEN-1:0] out_imag_q;
    logic            coef_err_q;

    logic            coef_fire;
    logic            in_fire;
    logic            coef_idx_ok;

    // A pending coefficient wins over a pending sample, so in_ready drops
    // combinationally while coef_valid is high.
    assign coef_ready_o = (state_q == ST_IDLE);
    assign in_ready_o   = (state_q == ST_IDLE) && !out_valid_q && !coef_valid_i;
    assign coef_fire    = coef_valid_i && coef_ready_o;
    assign in_fire      = in_valid_i && in_ready_o;
    assign coef_idx_ok  = ({1'b0, coef_idx_i} < NTAPS_L);

    assign scie_valid_o    = scie_valid_q;
    assign scie_insn_o     = scie_insn_q;
    assign scie_rs1_real_o = scie_rs1_real_q;
    assign scie_rs1_imag_o = scie_rs1_imag_q;
    assign scie_rs2_o      = scie_rs2_q;
    assign out_valid_o     = out_valid_q;
    assign out_real_o      = out_real_q;
    assign out_imag_o      = out_imag_q;
    assign coef_err_o      = coef_err_q;
    assign busy_o          = (state_q != ST_IDLE) || out_valid_q;

    // FSM with registered SCIE command outputs and inline result holding register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            scie_valid_q    <= 1'b0;
            scie_insn_q     <= '0;
            scie_rs1_real_q <= '0;
            scie_rs1_imag_q <= '0;
            scie_rs2_q      <= '0;
            out_valid_q     <= 1'b0;
            out_real_q      <= '0;
            out_imag_q      <= '0;
            coef_err_q      <= 1'b0;
        end else begin
            // Command is a single-cycle pulse; operands hold between commands.
            scie_valid_q <= 1'b0;
            scie_insn_q  <= '0;

            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
                out_real_q  <= '0;
                out_imag_q  <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (coef_fire) begin
                        if (coef_idx_ok) begin
                            state_q         <= ST_LOAD;
                            scie_valid_q    <= 1'b1;
                            scie_insn_q     <= XLEN'(OPC_LOAD);
                            scie_rs1_real_q <= coef_real_i;
                            scie_rs1_imag_q <= coef_imag_i;
                            scie_rs2_q      <= XLEN'(coef_idx_i);
                        end else begin
                            coef_err_q <= 1'b1;
                        end
                    end else if (in_fire) begin
                        state_q         <= ST_PUSH;
                        scie_valid_q    <= 1'b1;
                        scie_insn_q     <= XLEN'(OPC_PUSH);
                        scie_rs1_real_q <= in_real_i;
                        scie_rs1_imag_q <= in_imag_i;
                    end
                end
                ST_LOAD: state_q <= ST_IDLE;
                ST_PUSH: state_q <= ST_WAIT;
                ST_WAIT: begin
                    state_q      <= ST_READ;
                    scie_valid_q <= 1'b1;
                    scie_insn_q  <= XLEN'(OPC_READ);
                end
                ST_READ: state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b1;
                    out_real_q  <= scie_rd_real_i;
                    out_imag_q  <= scie_rd_imag_i;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// Scoreboard bench for scie_fir_sequencer: stimulus pushes expected SCIE
// commands and results, a negedge monitor pops and compares them.
module tb_scie_fir_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        coef_valid_i, coef_ready_o;
    logic [2:0]  coef_idx_i;
    logic [31:0] coef_real_i, coef_imag_i;
    logic        in_valid_i, in_ready_o;
    logic [31:0] in_real_i, in_imag_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_real_o, out_imag_o;
    logic        scie_valid_o;
    logic [31:0] scie_insn_o, scie_rs1_real_o, scie_rs1_imag_o, scie_rs2_o;
    logic [31:0] scie_rd_real_i, scie_rd_imag_i;
    logic        busy_o, coef_err_o;

    scie_fir_sequencer #(.NTAPS(5), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .coef_valid_i(coef_valid_i), .coef_ready_o(coef_ready_o),
        .coef_idx_i(coef_idx_i), .coef_real_i(coef_real_i), .coef_imag_i(coef_imag_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_real_i(in_real_i), .in_imag_i(in_imag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_real_o(out_real_o), .out_imag_o(out_imag_o),
        .scie_valid_o(scie_valid_o), .scie_insn_o(scie_insn_o),
        .scie_rs1_real_o(scie_rs1_real_o), .scie_rs1_imag_o(scie_rs1_imag_o),
        .scie_rs2_o(scie_rs2_o),
        .scie_rd_real_i(scie_rd_real_i), .scie_rd_imag_i(scie_rd_imag_i),
        .busy_o(busy_o), .coef_err_o(coef_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [31:0] insn;
        logic [31:0] re;
        logic [31:0] im;
        logic [31:0] rs2;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [31:0] re;
        logic [31:0] im;
    } res_t;

    cmd_t cmd_q[$];
    res_t res_q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Bench model of the operand registers, which hold between commands.
    logic [31:0] m_rs1_re = '0, m_rs1_im = '0, m_rs2 = '0;
    logic [31:0] stub_re = '0, stub_im = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk_i) cyc++;

    // SCIE stub: result appears the cycle after a read command, junk otherwise.
    always @(posedge clk_i) begin
        if (scie_valid_o && scie_insn_o == 32'd91) begin
            scie_rd_real_i <= stub_re;
            scie_rd_imag_i <= stub_im;
        end else begin
            scie_rd_real_i <= $urandom;
            scie_rd_imag_i <= $urandom;
        end
    end

    // Monitor: commands, result arrival and result stability.
    logic        ov_prev = 1'b0, rdy_prev = 1'b0;
    logic [31:0] held_re = '0, held_im = '0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            ov_prev = 1'b0;
        end else begin
            if (scie_valid_o) begin
                if (cmd_q.size() == 0) begin
                    total++;
                    $display("FAIL cmd_unexpected: got insn %0d at cycle %0d expected none", scie_insn_o, cyc);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    check("cmd_cycle", 32'(cyc), 32'(e.cyc));
                    check("cmd_insn", scie_insn_o, e.insn);
                    check("cmd_rs1_real", scie_rs1_real_o, e.re);
                    check("cmd_rs1_imag", scie_rs1_imag_o, e.im);
                    check("cmd_rs2", scie_rs2_o, e.rs2);
                end
            end else begin
                check("insn_zero_when_idle", scie_insn_o, 32'd0);
            end
            if (out_valid_o && !ov_prev) begin
                if (res_q.size() == 0) begin
                    total++;
                    $display("FAIL out_unexpected: got out_valid at cycle %0d expected none", cyc);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("out_cycle", 32'(cyc), 32'(r.cyc));
                    check("out_real", out_real_o, r.re);
                    check("out_imag", out_imag_o, r.im);
                end
            end else if (out_valid_o && ov_prev && !rdy_prev) begin
                check("out_real_stable", out_real_o, held_re);
                check("out_imag_stable", out_imag_o, held_im);
            end
            ov_prev  = out_valid_o;
            rdy_prev = out_ready_i;
            held_re  = out_real_o;
            held_im  = out_imag_o;
        end
    end

    task automatic wait_coef_ready();
        for (int n = 0; n < 50 && !coef_ready_o; n++) @(negedge clk_i);
        check("coef_ready_wait", 32'(coef_ready_o), 32'd1);
    endtask

    task automatic wait_in_ready();
        for (int n = 0; n < 50 && !in_ready_o; n++) @(negedge clk_i);
        check("in_ready_wait", 32'(in_ready_o), 32'd1);
    endtask

    task automatic send_coef(input logic [2:0] idx, input logic [31:0] re, input logic [31:0] im);
        wait_coef_ready();
        coef_valid_i = 1'b1;
        coef_idx_i   = idx;
        coef_real_i  = re;
        coef_imag_i  = im;
        if (idx < 3'd5) begin
            m_rs1_re = re; m_rs1_im = im; m_rs2 = {29'd0, idx};
            cmd_q.push_back('{cyc + 1, 32'd11, re, im, m_rs2});
        end
        @(negedge clk_i);
        coef_valid_i = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] re, input logic [31:0] im,
                               input logic [31:0] rd_re, input logic [31:0] rd_im);
        wait_in_ready();
        in_valid_i = 1'b1;
        in_real_i  = re;
        in_imag_i  = im;
        stub_re    = rd_re;
        stub_im    = rd_im;
        m_rs1_re = re; m_rs1_im = im;
        cmd_q.push_back('{cyc + 1, 32'd43, re, im, m_rs2});
        cmd_q.push_back('{cyc + 3, 32'd91, re, im, m_rs2});
        res_q.push_back('{cyc + 5, rd_re, rd_im});
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    // Hold out_ready low for 'hold' cycles, then consume the result.
    task automatic consume(input int hold);
        for (int n = 0; n < 20 && !out_valid_o; n++) @(negedge clk_i);
        check("out_valid_wait", 32'(out_valid_o), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("in_ready_while_out_pending", 32'(in_ready_o), 32'd0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check("out_valid_cleared", 32'(out_valid_o), 32'd0);
        check("out_real_cleared", out_real_o, 32'd0);
        check("out_imag_cleared", out_imag_o, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_scie_valid"}, 32'(scie_valid_o), 32'd0);
        check({tag, "_scie_insn"}, scie_insn_o, 32'd0);
        check({tag, "_rs1_real"}, scie_rs1_real_o, 32'd0);
        check({tag, "_rs1_imag"}, scie_rs1_imag_o, 32'd0);
        check({tag, "_rs2"}, scie_rs2_o, 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_out_real"}, out_real_o, 32'd0);
        check({tag, "_out_imag"}, out_imag_o, 32'd0);
        check({tag, "_coef_err"}, 32'(coef_err_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        coef_valid_i = 1'b0; coef_idx_i = '0; coef_real_i = '0; coef_imag_i = '0;
        in_valid_i = 1'b0; in_real_i = '0; in_imag_i = '0; out_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        check("reset_coef_ready", 32'(coef_ready_o), 32'd1);
        check("reset_in_ready", 32'(in_ready_o), 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Coefficient load, idx 2.
        send_coef(3'd2, -32'sd2492312, 32'sd2743299);
        @(negedge clk_i);

        // Sample with result held off for 3 cycles.
        send_sample(-32'sd508237, -32'sd2408467, -32'sd77560472, -32'sd21320522);
        consume(3);

        // Boundary tap indices.
        send_coef(3'd0, 32'h0000_0001, 32'hFFFF_FFFF);
        send_coef(3'd4, 32'h8000_0000, 32'h7FFF_FFFF);

        // Extreme sample values; coefficient load while the result is pending.
        send_sample(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF);
        for (int n = 0; n < 20 && !out_valid_o; n++) @(negedge clk_i);
        check("busy_while_out_pending", 32'(busy_o), 32'd1);
        send_coef(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        consume(0);

        // Coefficient and sample offered together: load first, push two cycles later.
        wait_coef_ready();
        coef_valid_i = 1'b1; coef_idx_i = 3'd3;
        coef_real_i = 32'h0000_0033; coef_imag_i = 32'hFFFF_FFCD;
        in_valid_i = 1'b1; in_real_i = 32'h0000_0100; in_imag_i = 32'hFFFF_FF00;
        stub_re = 32'h0BAD_F00D; stub_im = 32'hF00D_0BAD;
        #1;
        check("in_ready_coef_priority", 32'(in_ready_o), 32'd0);
        m_rs2 = 32'd3;
        cmd_q.push_back('{cyc + 1, 32'd11, 32'h0000_0033, 32'hFFFF_FFCD, 32'd3});
        cmd_q.push_back('{cyc + 3, 32'd43, 32'h0000_0100, 32'hFFFF_FF00, 32'd3});
        cmd_q.push_back('{cyc + 5, 32'd91, 32'h0000_0100, 32'hFFFF_FF00, 32'd3});
        res_q.push_back('{cyc + 7, 32'h0BAD_F00D, 32'hF00D_0BAD});
        m_rs1_re = 32'h0000_0100; m_rs1_im = 32'hFFFF_FF00;
        @(negedge clk_i);
        coef_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        consume(0);

        // Out-of-range tap indices: no command, sticky error.
        send_coef(3'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        check("bad_idx_coef_err", 32'(coef_err_o), 32'd1);
        check("bad_idx_stays_idle", 32'(busy_o), 32'd0);
        send_coef(3'd7, 32'h1111_1111, 32'h2222_2222);
        send_sample(32'd5, 32'd6, 32'd7, 32'd8);
        consume(1);
        check("coef_err_sticky", 32'(coef_err_o), 32'd1);

        // Reset during WAIT drops the sample; next sample sequences normally.
        wait_in_ready();
        in_valid_i = 1'b1; in_real_i = 32'h0000_0AAA; in_imag_i = 32'h0000_0BBB;
        cmd_q.push_back('{cyc + 1, 32'd43, 32'h0000_0AAA, 32'h0000_0BBB, m_rs2});
        @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        cmd_q.delete();
        res_q.delete();
        m_rs1_re = '0; m_rs1_im = '0; m_rs2 = '0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        send_sample(-32'sd1, 32'sd1, -32'sd42, 32'sd42);
        consume(1);

        for (int n = 0; n < 30 && (cmd_q.size() != 0 || res_q.size() != 0); n++) @(negedge clk_i);
        check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scie_fir_sequencer.md
SCIE_FIR_SEQUENCER -- requirements
Module: scie_fir_sequencer

Interface
REQ-001 Parameters, one per line: NTAPS, default 5, number of complex FIR coefficients; XLEN, default 32, data/instruction width.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 coef_valid / coef_ready  input / output  1 / 1  coefficient-load handshake.
REQ-005 coef_idx  input  3  tap index; coef_real, coef_imag  input  XLEN each  signed coefficient.
REQ-006 in_valid / in_ready  input / output  1 / 1  sample handshake; in_real, in_imag  input  XLEN each  signed sample.
REQ-007 out_valid / out_ready  output / input  1 / 1  result handshake; out_real, out_imag  output  XLEN each  signed filter result.
REQ-008 scie_valid  output  1; scie_insn  output  XLEN; scie_rs1_real, scie_rs1_imag, scie_rs2  output  XLEN each  registered command to the downstream SCIE pipelined unit.
REQ-009 scie_rd_real, scie_rd_imag  input  XLEN each  SCIE result, valid one cycle after a read command.
REQ-010 busy  output  1  state != IDLE or out_valid; coef_err  output  1  sticky bad-index flag.

Function
REQ-011 FSM states: IDLE, LOAD, PUSH, WAIT, READ, CAPTURE; all SCIE outputs are registered.
REQ-012 coef_ready = (state == IDLE); in_ready = (state == IDLE) and not out_valid.
REQ-013 Coefficient and sample handshakes both pending in IDLE: the coefficient is accepted; in_ready is deasserted in that cycle.
REQ-014 Coefficient accepted with coef_idx < NTAPS: next cycle LOAD; scie_valid=1, scie_insn=11, scie_rs1 = coefficient, scie_rs2 = zero-extended coef_idx; then IDLE.
REQ-015 Coefficient accepted with coef_idx >= NTAPS: no SCIE command is issued, coef_err is set, and the state remains IDLE.
REQ-016 Sample accepted: PUSH (scie_valid=1, insn=43, rs1 = sample), WAIT (scie_valid=0), READ (scie_valid=1, insn=91), CAPTURE (scie_valid=0, scie_rd latched into out_real/out_imag), then IDLE.
REQ-017 out_valid rises the cycle after CAPTURE, i.e. 5 cycles after the in handshake edge.
REQ-018 out_valid, out_real and out_imag hold stable until out_ready is high; they clear on that edge.
REQ-019 Coefficient loads are permitted while out_valid is pending.
REQ-020 scie_rs1/scie_rs2 hold their last value when scie_valid=0; scie_insn is 0 when scie_valid=0.
REQ-021 Arithmetic is pass-through only; no width conversion; signed values are passed bit-exact.

Reset
REQ-022 reset low forces, immediately and asynchronously: state=IDLE, all SCIE outputs 0, out_valid=0, out_real=out_imag=0, coef_err=0, busy=0.
REQ-023 An in-flight sample or coefficient is dropped on reset without a partial command; operation resumes on the first edge after release.

Structure
REQ-024 Shared package scie_pkg holds the opcode constants (OPC_LOAD=11, OPC_PUSH=43, OPC_READ=91), NTAPS and the FSM state enum.
REQ-025 Single module; no sub-module is required. The output holding register is inline.

Verification
REQ-026 Coefficient idx=2, real=-2492312, imag=2743299 -> one cycle later exactly one scie_valid pulse with insn=11, rs1=(-2492312, 2743299), rs2=2.
REQ-027 Sample (-508237, -2408467); SCIE stub returns (-77560472, -21320522) -> scie_valid pattern 1,0,1 with insn 43 then 91; out_valid at +5 cycles with out=(-77560472, -21320522).
REQ-028 out_ready held low 3 cycles after out_valid -> out values stable, in_ready=0; the result is consumed on the first out_ready-high edge.
REQ-029 coef_valid and in_valid asserted together in IDLE -> the LOAD command is issued first and the sample PUSH follows 2 cycles later.
REQ-030 coef_idx=5 -> no scie_valid and coef_err=1 until reset; reset asserted during WAIT -> all outputs 0 asynchronously and the next sample sequences normally.
